// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between IF and the IF/ID register.
// Holds up to DEPTH {pc, instr} pairs in a circular FIFO. Handshakes on both
// sides follow valid/ready: a transfer happens on a rising edge where both
// valid and ready are high; valid never depends on ready, and enq_ready does
// not depend on deq_ready. A flush (redirect) empties the queue and drops any
// transfer attempted in the same cycle. When empty, decode sees a NOP at pc 0.
module fetch_queue #(
  parameter int unsigned     DEPTH = 4,
  parameter int unsigned     XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pc_mem_d    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic enq_fire;
  logic deq_fire;

  // Status and head outputs come from registered state only.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    count     = count_q;
    enq_ready = !full;
    deq_valid = !empty;
    deq_pc    = empty ? '0  : pc_mem_q[rd_ptr_q];
    deq_instr = empty ? NOP : instr_mem_q[rd_ptr_q];
    enq_fire  = enq_valid & enq_ready;
    deq_fire  = deq_valid & deq_ready;
  end

  // Next-state: flush wins; otherwise write at tail, advance pointers, track occupancy.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        pc_mem_d[wr_ptr_q]    = enq_pc;
        instr_mem_d[wr_ptr_q] = enq_instr;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear, storage included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;
  logic [2:0]      count;
  logic            empty;
  logic            full;

  // Reference model: the queue contents, oldest first, as {pc, instr}.
  logic [2*XLEN-1:0] exp_q[$];

  int n_cmp;
  int n_bad;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks all status outputs against model occupancy sz.
  task automatic chk_status(input int sz);
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("enq_ready", 64'(enq_ready), 64'(sz < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'(sz != 0));
    if (sz == 0) begin
      chk("deq_instr_nop", 64'(deq_instr), 64'(NOP_W));
      chk("deq_pc_zero", 64'(deq_pc), 64'd0);
    end
  endtask

  // Driver: one cycle of stimulus. Inputs change at negedge; status is checked
  // at +1, the monitor runs at +2, the model advances at +3.
  task automatic step(input logic f, input logic ev, input logic [31:0] pc,
                      input logic [31:0] ins, input logic dr);
    int sz;
    @(negedge clk);
    flush     = f;
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    deq_ready = dr;
    #1;
    sz = exp_q.size();
    chk_status(sz);
    #2;
    if (f) exp_q.delete();
    else if (ev && sz < DEPTH) exp_q.push_back({pc, ins});
  endtask

  // Monitor: whenever the head transfers, it must match the oldest model entry.
  initial begin
    logic [2*XLEN-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deq_unexpected: got pc %0h with model empty", deq_pc);
        end else begin
          e = exp_q.pop_front();
          chk("deq_pc", 64'(deq_pc), 64'(e[63:32]));
          chk("deq_instr", 64'(deq_instr), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    flush = 1'b0;
    enq_valid = 1'b0;
    enq_pc = '0;
    enq_instr = '0;
    deq_ready = 1'b0;

    // Reset / idle
    repeat (3) @(negedge clk);
    #1;
    chk_status(0);
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Fill and drain, fifth pair held off while full
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Streaming through the pointer wrap
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hB0 + 32'(i), 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush with simultaneous enq and deq
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h20 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'h40, 32'hC4, 1'b1);
    step(1'b0, 1'b1, 32'h80, 32'hC8, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Full + deq: first offer refused, the repeated offer accepted
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'hD0 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h110, 32'hD4, 1'b1);
    step(1'b0, 1'b1, 32'h110, 32'hD4, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream, between clock edges
    step(1'b0, 1'b1, 32'h200, 32'hE0, 1'b0);
    step(1'b0, 1'b1, 32'h204, 32'hE1, 1'b0);
    @(negedge clk);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk_status(2);
    #2;
    rst = 1'b0;
    #1;
    chk_status(0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
